// File: rtl/mult_bist_checker.sv
// Purpose : on-chip self-check monitor for the pipelined Booth multiplier; samples one
//           operand pair, captures the matching product, recomputes it and counts fails.
// Latency : done pulses in the cycle after posedge k+LATENCY+WIDTH (k = en sample edge).
// Backpressure: none; en is ignored while a check is in flight (busy=1), and operand
//               pairs presented in that time are simply not checked.
//
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous active-high reset; aborts any check and clears all state
//   en       arm a check (sampled only in IDLE)
//   mx, my   operands, same signals the multiplier samples
//   product  multiplier output (2*WIDTH)
//   busy     high from the en sample edge through the compare cycle
//   done     one-cycle pulse in the compare cycle
//   err_flag sticky mismatch flag, cleared only by RST
//   chk_cnt  completed checks (wraps)
//   err_cnt  mismatches (saturates at all-ones)
//
// Optional error log, enabled by defining MULT_CHK_ERRLOG_EN:
//   err_mx, err_my, err_prod, err_gold hold the operands, captured product and golden
//   product of the first mismatch seen since reset.

module mult_bist_checker #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 en,
    input  logic [WIDTH-1:0]     mx,
    input  logic [WIDTH-1:0]     my,
    input  logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic                 err_flag,
    output logic [CNT_W-1:0]     chk_cnt,
    output logic [CNT_W-1:0]     err_cnt
`ifdef MULT_CHK_ERRLOG_EN
    ,
    output logic [WIDTH-1:0]     err_mx,
    output logic [WIDTH-1:0]     err_my,
    output logic [2*WIDTH-1:0]   err_prod,
    output logic [2*WIDTH-1:0]   err_gold
`endif
);

    localparam int PW    = 2 * WIDTH;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CALC = 2'd2,
        S_CMP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // opx is kept at full product width and shifted left once per CALC step, so at
    // every step it already equals the zero-extended multiplicand shifted by the
    // current bit index; no barrel shifter is needed.
    logic [PW-1:0]    opx;
    logic [WIDTH-1:0] opy;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    dut_p;
    logic [LAT_W-1:0] lat_cnt;
    logic [BIT_W-1:0] bit_cnt;

    logic lat_last;
    logic bit_last;
    logic mismatch;

    assign lat_last = (lat_cnt == '0);
    assign bit_last = (bit_cnt == '0);
    assign mismatch = (acc != dut_p);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (lat_last) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (bit_last) begin
                    state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, latency wait, shift-add engine, compare
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            opx     <= '0;
            opy     <= '0;
            acc     <= '0;
            dut_p   <= '0;
            lat_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        opx     <= {{WIDTH{1'b0}}, mx};
                        opy     <= my;
                        lat_cnt <= LAT_W'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (lat_last) begin
                        // The only edge at which product is looked at.
                        dut_p   <= product;
                        acc     <= '0;
                        bit_cnt <= BIT_W'(WIDTH - 1);
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_CALC: begin
                    if (opy[0]) begin
                        acc <= acc + opx;
                    end
                    opx     <= opx << 1;
                    opy     <= opy >> 1;
                    bit_cnt <= bit_cnt - BIT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chk_cnt  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (state == S_CMP) begin
            chk_cnt <= chk_cnt + CNT_W'(1);
            if (mismatch) begin
                err_flag <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef MULT_CHK_ERRLOG_EN
    // opy is consumed by the shift-add engine and opx is shifted, so the original
    // operands are kept in separate copies for the log.
    logic [WIDTH-1:0] mx_cpy;
    logic [WIDTH-1:0] my_cpy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mx_cpy <= '0;
            my_cpy <= '0;
        end else if (state == S_IDLE && en) begin
            mx_cpy <= mx;
            my_cpy <= my;
        end
    end

    // Only the first failure is logged; err_flag still being low marks it as first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_mx   <= '0;
            err_my   <= '0;
            err_prod <= '0;
            err_gold <= '0;
        end else if (state == S_CMP && mismatch && !err_flag) begin
            err_mx   <= mx_cpy;
            err_my   <= my_cpy;
            err_prod <= dut_p;
            err_gold <= acc;
        end
    end
`endif

endmodule

// File: tb/tb_mult_bist_checker.sv
// Self-checking bench for mult_bist_checker. Two instances share one stimulus stream:
// the default-counter instance and one with 4-bit counters for wrap/saturation.
module tb_mult_bist_checker;

    localparam int W   = 32;
    localparam int LAT = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic           en;
    logic [W-1:0]   mx;
    logic [W-1:0]   my;
    logic [2*W-1:0] product;

    logic           busy, done, err_flag;
    logic [15:0]    chk_cnt, err_cnt;
    logic           busy4, done4, err_flag4;
    logic [3:0]     chk_cnt4, err_cnt4;

`ifdef MULT_CHK_ERRLOG_EN
    logic [W-1:0]   err_mx, err_my, err_mx4, err_my4;
    logic [2*W-1:0] err_prod, err_gold, err_prod4, err_gold4;
`endif

    mult_bist_checker #(.WIDTH(W), .LATENCY(LAT), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .en(en), .mx(mx), .my(my), .product(product),
        .busy(busy), .done(done), .err_flag(err_flag),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt)
`ifdef MULT_CHK_ERRLOG_EN
        , .err_mx(err_mx), .err_my(err_my), .err_prod(err_prod), .err_gold(err_gold)
`endif
    );

    mult_bist_checker #(.WIDTH(W), .LATENCY(LAT), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .en(en), .mx(mx), .my(my), .product(product),
        .busy(busy4), .done(done4), .err_flag(err_flag4),
        .chk_cnt(chk_cnt4), .err_cnt(err_cnt4)
`ifdef MULT_CHK_ERRLOG_EN
        , .err_mx(err_mx4), .err_my(err_my4), .err_prod(err_prod4), .err_gold(err_gold4)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0]    m_chk, m_err;
    logic [3:0]     m_chk4, m_err4;
    logic           m_flag;
    logic [W-1:0]   m_emx, m_emy;
    logic [2*W-1:0] m_eprod, m_egold;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_chk = '0; m_err = '0; m_chk4 = '0; m_err4 = '0; m_flag = 1'b0;
        m_emx = '0; m_emy = '0; m_eprod = '0; m_egold = '0;
    endtask

    // One completed check: golden product by plain multiplication at full width.
    task automatic model_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [2*W-1:0] p);
        logic [2*W-1:0] gold;
        gold = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        m_chk  = m_chk + 16'd1;
        m_chk4 = m_chk4 + 4'd1;
        if (gold != p) begin
            if (!m_flag) begin
                m_emx = x; m_emy = y; m_eprod = p; m_egold = gold;
            end
            m_flag = 1'b1;
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            if (m_err4 != 4'hF) m_err4 = m_err4 + 4'd1;
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_chk"},   64'(chk_cnt),   64'(m_chk));
        check({tag, "_err"},   64'(err_cnt),   64'(m_err));
        check({tag, "_flag"},  64'(err_flag),  64'(m_flag));
        check({tag, "_chk4"},  64'(chk_cnt4),  64'(m_chk4));
        check({tag, "_err4"},  64'(err_cnt4),  64'(m_err4));
        check({tag, "_flag4"}, 64'(err_flag4), 64'(m_flag));
`ifdef MULT_CHK_ERRLOG_EN
        check({tag, "_emx"},   64'(err_mx),    64'(m_emx));
        check({tag, "_emy"},   64'(err_my),    64'(m_emy));
        check({tag, "_eprod"}, err_prod,       m_eprod);
        check({tag, "_egold"}, err_gold,       m_egold);
        check({tag, "_eprod4"}, err_prod4,     m_eprod);
`endif
    endtask

    // Called #1 after an edge with the DUT in IDLE. The next posedge is k. The product
    // is valid only around posedge k+LAT; random values surround it and the operands
    // are scrambled right after capture.
    task automatic run_check(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [2*W-1:0] p, input bit hold_en);
        check({tag, "_idle_before"}, 64'(busy), 64'd0);
        en = 1'b1; mx = x; my = y;
        @(posedge CLK); #1;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        en = hold_en; mx = $urandom; my = $urandom; product = {$urandom, $urandom};
        repeat (LAT - 1) @(posedge CLK);
        #1 product = p;
        @(posedge CLK);
        #1 product = {$urandom, $urandom};
        repeat (W - 1) @(posedge CLK);
        #1;
        check({tag, "_done_early"}, 64'(done), 64'd0);
        @(posedge CLK); #1;
        check({tag, "_done"},  64'(done),  64'd1);
        check({tag, "_done4"}, 64'(done4), 64'd1);
        check({tag, "_busy_cmp"}, 64'(busy), 64'd1);
        model_cmp(x, y, p);
        @(posedge CLK); #1;
        check({tag, "_done_end"}, 64'(done), 64'd0);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check_stats(tag);
    endtask

    initial begin
        logic [W-1:0]   rx, ry;
        logic [2*W-1:0] rp;
        model_reset();

        // Reset held for 3 cycles with random inputs and en active
        RST = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mx = $urandom; my = $urandom; product = {$urandom, $urandom};
            @(posedge CLK); #1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check_stats("rst");
        end
        en = 1'b0;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 check("idle_no_en", 64'(busy), 64'd0);

        run_check("pass_3x5", 32'd3, 32'd5, 64'd15, 1'b0);
        run_check("pass_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_check("mis_3x5", 32'd3, 32'd5, 64'd14, 1'b0);
        run_check("pass_after_mis", 32'd7, 32'd9, 64'd63, 1'b0);

        // Random pairs, roughly half with a single flipped product bit
        for (int i = 0; i < 8; i++) begin
            rx = $urandom; ry = $urandom;
            if (i == 0) rx = '0;
            rp = {{W{1'b0}}, rx} * {{W{1'b0}}, ry};
            if ($urandom_range(1) == 1) rp = rp ^ (64'd1 << $urandom_range(63));
            run_check("rand", rx, ry, rp, 1'b0);
        end

        // Abort during the 10th CALC cycle
        en = 1'b1; mx = 32'd11; my = 32'd13;
        @(posedge CLK);
        #1 en = 1'b0;
        product = 64'd143;
        repeat (LAT + 9) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check_stats("abort");
        @(posedge CLK);
        #1 RST = 1'b0;
        check("abort_no_done", 64'(done), 64'd0);
        run_check("after_abort", 32'd11, 32'd13, 64'd143, 1'b0);

        // Counter limits: 20 back-to-back mismatching checks with en held high
        RST = 1'b1;
        #2 model_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx = $urandom; ry = $urandom;
            rp = ({{W{1'b0}}, rx} * {{W{1'b0}}, ry}) + 64'd1;
            run_check("b2b_mis", rx, ry, rp, i != 19);
        end
        check("sat_err4", 64'(err_cnt4), 64'd15);
        check("wrap_chk4", 64'(chk_cnt4), 64'd4);
        check("b2b_err16", 64'(err_cnt), 64'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
